// File: rtl/local_packetizer_pkg.sv
// Shared packet layout, direction codes and packetizer FSM states for the
// local packetizer and the router it feeds.
package local_packetizer_pkg;

  localparam int ADDR_W = 2;
  localparam int PAY_W  = 36;
  localparam int PKT_W  = 40;

  localparam int SRC_HI = 39;
  localparam int SRC_LO = 38;
  localparam int DST_HI = 37;
  localparam int DST_LO = 36;
  localparam int PAY_HI = 35;
  localparam int PAY_LO = 0;

  typedef enum logic [1:0] {
    DIR_NORTH = 2'b00,
    DIR_EAST  = 2'b01,
    DIR_SOUTH = 2'b10,
    DIR_WEST  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'b00,
    ST_SEND        = 2'b01,
    ST_WAIT_CREDIT = 2'b10
  } pk_state_e;

  function automatic logic [PKT_W-1:0] form_pkt(input logic [ADDR_W-1:0] src,
                                                input logic [ADDR_W-1:0] dst,
                                                input logic [PAY_W-1:0]  pay);
    logic [PKT_W-1:0] p;
    p                = '0;
    p[SRC_HI:SRC_LO] = src;
    p[DST_HI:DST_LO] = dst;
    p[PAY_HI:PAY_LO] = pay;
    return p;
  endfunction

endpackage

// File: rtl/local_packetizer_fifo.sv
// Packet queue: power-of-two depth FIFO with a combinational head read.
module pkt_fifo #(
  parameter int DATA_W = 40,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/local_packetizer.sv
// Wraps PE payloads into routed packets and meters them into the router's
// local channel under credit-based flow control.
module local_packetizer
  import local_packetizer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] current_location,
  input  logic              pe_valid,
  output logic              pe_ready,
  input  logic [ADDR_W-1:0] pe_dest,
  input  logic [PAY_W-1:0]  pe_data,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic [PKT_W-1:0]  pkt_out,
  input  logic              credit_return,
  output logic              self_err,
  output logic              credit_err,
  output logic [7:0]        pkt_count
);

  localparam int CW = $clog2(CREDITS + 1);

  pk_state_e        state;
  pk_state_e        state_nxt;
  logic [CW-1:0]    credits;
  logic [CW-1:0]    credits_nxt;
  logic             cr_overflow;
  logic             accept;
  logic             is_self;
  logic             push;
  logic             pop;
  logic             hs;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PKT_W-1:0] fifo_dout;

  assign pe_ready  = rst_n & ~fifo_full;
  assign accept    = pe_valid & pe_ready;
  assign is_self   = (pe_dest == current_location);
  assign push      = accept & ~is_self;
  assign pkt_valid = rst_n & (state == ST_SEND);
  assign hs        = pkt_valid & pkt_ready;

  // Stage 0: accepted payloads queued as complete packets
  pkt_fifo #(
    .DATA_W (PKT_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (form_pkt(current_location, pe_dest, pe_data)),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    credits_nxt = credits;
    cr_overflow = 1'b0;
    if (hs && !credit_return) begin
      credits_nxt = credits - CW'(1);
    end else if (credit_return && !hs) begin
      if (credits == CW'(CREDITS)) cr_overflow = 1'b1;
      else                         credits_nxt = credits + CW'(1);
    end
  end

  // Back-to-back sends look at the post-handshake credit count.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (credits != '0) begin
            pop       = 1'b1;
            state_nxt = ST_SEND;
          end else begin
            state_nxt = ST_WAIT_CREDIT;
          end
        end
      end
      ST_WAIT_CREDIT: begin
        if (credits != '0) begin
          pop       = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (hs) begin
          if (!fifo_empty && credits_nxt != '0) pop = 1'b1;
          else if (!fifo_empty)                 state_nxt = ST_WAIT_CREDIT;
          else                                  state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage 1: packet held on the local channel until handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      credits    <= CW'(CREDITS);
      pkt_out    <= '0;
      self_err   <= 1'b0;
      credit_err <= 1'b0;
      pkt_count  <= 8'd0;
    end else begin
      state    <= state_nxt;
      credits  <= credits_nxt;
      self_err <= accept & is_self;
      if (pop)         pkt_out    <= fifo_dout;
      if (cr_overflow) credit_err <= 1'b1;
      if (hs)          pkt_count  <= pkt_count + 8'd1;
    end
  end

endmodule

// File: doc/local_packetizer.md
LOCAL_PACKETIZER -- requirements
Module: local_packetizer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of entries in the packet queue (a power of two, at least 2).
REQ-002 The block SHALL have parameter CREDITS, default 4, meaning the downstream local-channel FIFO capacity in packets.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port current_location, input, 2 bits: this router's address.
REQ-006 The block SHALL have port pe_valid, input, 1 bit: the processing element offers a payload.
REQ-007 The block SHALL have port pe_ready, output, 1 bit: the block accepts the payload this cycle.
REQ-008 The block SHALL have port pe_dest, input, 2 bits: the destination router address.
REQ-009 The block SHALL have port pe_data, input, 36 bits: the payload.
REQ-010 The block SHALL have port pkt_valid, output, 1 bit: pkt_out holds a valid packet.
REQ-011 The block SHALL have port pkt_ready, input, 1 bit: the router local channel accepts the packet.
REQ-012 The block SHALL have port pkt_out, output, 40 bits: the formed packet.
REQ-013 The block SHALL have port credit_return, input, 1 bit: a one-cycle pulse meaning one downstream slot has been freed.
REQ-014 The block SHALL have port self_err, output, 1 bit: a one-cycle pulse meaning a payload addressed to this router was dropped.
REQ-015 The block SHALL have port credit_err, output, 1 bit: a sticky flag meaning a credit_return arrived while credits were already at CREDITS.
REQ-016 The block SHALL have port pkt_count, output, 8 bits: the number of packets sent, wrapping from 255 to 0.

Function
REQ-017 The block SHALL form each packet as [39:38]=current_location sampled at accept, [37:36]=pe_dest, [35:0]=pe_data.
REQ-018 The block SHALL drive pe_ready = rst_n AND NOT queue_full, and SHALL treat a payload as accepted only in a cycle where pe_valid and pe_ready are both 1.
REQ-019 If an accepted payload has pe_dest equal to current_location, the block SHALL NOT enqueue it and SHALL assert self_err for exactly the following cycle.
REQ-020 The queue SHALL be FIFO-ordered; a push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-021 The block SHALL implement an FSM with states IDLE, SEND and WAIT_CREDIT.
REQ-022 In IDLE with the queue non-empty: if credits > 0 the block SHALL pop the head into the pkt_out register and go to SEND; if credits = 0 it SHALL go to WAIT_CREDIT without popping.
REQ-023 In WAIT_CREDIT, once credits > 0 the block SHALL pop the head into pkt_out and go to SEND.
REQ-024 In SEND: pkt_valid = 1, and pkt_out SHALL be held stable until pkt_valid and pkt_ready are both 1.
REQ-025 On a SEND handshake: if the queue is non-empty and credits-after-update > 0, the block SHALL pop the next packet the same cycle and stay in SEND (back-to-back transfer); if the queue is non-empty and no credits remain, go to WAIT_CREDIT; otherwise go to IDLE.
REQ-026 The credit counter SHALL reset to CREDITS, decrement by 1 on each pkt handshake and increment by 1 on each credit_return.
REQ-027 A credit_return and a pkt handshake in the same cycle SHALL leave the credit counter unchanged.
REQ-028 A credit_return at CREDITS with no simultaneous handshake SHALL leave the counter saturated at CREDITS and SHALL set credit_err.
REQ-029 Minimum latency SHALL be: a payload accepted in cycle N appears with pkt_valid = 1 in cycle N+2.
REQ-030 pkt_count SHALL increment by 1 on each pkt handshake.

Reset
REQ-031 While rst_n = 0 at a clock edge, the block SHALL set: FSM = IDLE, queue empty, credits = CREDITS, pkt_valid = 0, pkt_out = 0, self_err = 0, credit_err = 0, pkt_count = 0.
REQ-032 A reset asserted mid-transfer SHALL discard the packet in flight and all queued packets; no handshake completes in the reset cycle.

Structure
REQ-033 The packet field positions (source, destination, payload), the 2-bit direction encodings and the FSM state encodings SHALL live in a shared package used by this block and the router.
REQ-034 The queue SHALL be a sub-module, pkt_fifo, parameterised by width and depth.

Verification
REQ-035 The bench SHALL cover: current_location=2'b00, pe_dest=2'b11, pe_data=36'h123456789 accepted at cycle N -> pkt_out=40'h3123456789 with pkt_valid=1 at N+2.
REQ-036 The bench SHALL cover: pe_dest = current_location = 2'b10 -> no packet is sent, self_err pulses for 1 cycle, pkt_count is unchanged.
REQ-037 The bench SHALL cover: pkt_ready held at 1 and no credit_return, 6 payloads offered -> exactly 4 packets sent, FSM in WAIT_CREDIT, pkt_valid=0; one credit_return -> the 5th packet is sent.
REQ-038 The bench SHALL cover: pkt_ready held at 0 -> pe_ready falls to 0 when the queue is full (4 entries queued plus 1 held in pkt_out), and pkt_out stays stable.
REQ-039 The bench SHALL cover: credit_return while credits = 4 -> credit_err = 1 and credits stay at 4; credit_return concurrent with a handshake -> credits unchanged.
REQ-040 The bench SHALL cover: rst_n=0 during SEND -> the next cycle shows pkt_valid=0, pkt_count=0, pe_ready=0, and credits back at 4.
